// File: rtl/uart_tx_driver.sv
// uart_tx_driver: CPU-written byte FIFO feeding a UART transmitter (8N1).
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1, 11-bit frames).
module uart_tx_driver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int UART_BPS   = 128000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        iFpgaClock,
  input  logic        iCpuClock,
  input  logic        iCpuReset,
  input  logic        iUartCtrl,
  input  logic        iIoWrite,
  input  logic        iIoRead,
  input  logic [15:0] iWriteData,
  output logic        oUartToPc,
  output logic [15:0] oUartStatus
);

  localparam int DIV = CLK_FREQ / UART_BPS;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
  localparam logic [PW:0]   DEPTH = (PW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } st_t;
`endif

  logic       unused_hi;
  logic       wr_sel, rd_sel;
  logic [7:0] wdata_q;
  logic       req_q, clr_q;
  logic [3:0] flags_q, fl_s1_q, fl_s2_q;

  assign unused_hi = ^iWriteData[15:8];
  assign wr_sel    = iUartCtrl && iIoWrite;
  assign rd_sel    = iUartCtrl && iIoRead;

  // CPU side: latch store byte, toggle push/clear requests, sample status
  always_ff @(negedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      wdata_q     <= '0;
      req_q       <= 1'b0;
      clr_q       <= 1'b0;
      fl_s1_q     <= 4'b0010;
      fl_s2_q     <= 4'b0010;
      oUartStatus <= 16'h0002;
    end else begin
      fl_s1_q <= flags_q;
      fl_s2_q <= fl_s1_q;
      if (wr_sel) begin
        wdata_q <= iWriteData[7:0];
        req_q   <= ~req_q;
      end
      if (rd_sel) begin
        oUartStatus <= {12'h000, fl_s2_q};
        if (fl_s2_q[3]) clr_q <= ~clr_q;
      end
    end
  end

  logic [2:0] req_s_q, clr_s_q;
  logic       push_req, clr_req;

  // Two-flop toggle synchronisers, third stage detects the edge
  always_ff @(posedge iFpgaClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      req_s_q <= '0;
      clr_s_q <= '0;
    end else begin
      req_s_q <= {req_s_q[1:0], req_q};
      clr_s_q <= {clr_s_q[1:0], clr_q};
    end
  end

  assign push_req = req_s_q[2] ^ req_s_q[1];
  assign clr_req  = clr_s_q[2] ^ clr_s_q[1];

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0]   cnt_q;
  logic          full, empty, push, pop, ovf_q;
  st_t           st_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          par_q, tx_q, bit_end;

  assign full    = (cnt_q == DEPTH);
  assign empty   = (cnt_q == '0);
  assign push    = push_req && (!full || pop);
  assign bit_end = (baud_q == LAST);

  // Pop when idle, or at the end of STOP to chain frames without a gap
  always_comb begin
    pop = 1'b0;
    if (!empty)
      pop = (st_q == S_IDLE) || ((st_q == S_STOP) && bit_end);
  end

  // FIFO storage, written through the write pointer
  always_ff @(posedge iFpgaClock) begin
    if (push) mem_q[wp_q] <= wdata_q;
  end

  // FIFO pointers, occupancy, sticky overflow and status flags
  always_ff @(posedge iFpgaClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      flags_q <= 4'b0010;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (push_req && full && !pop) ovf_q <= 1'b1;
      else if (clr_req)             ovf_q <= 1'b0;
      flags_q <= {ovf_q, full, empty, (st_q != S_IDLE) || !empty};
    end
  end

  // Transmit FSM: one bit per DIV cycles, registered line output
  always_ff @(posedge iFpgaClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      st_q   <= S_IDLE;
      baud_q <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      tx_q   <= 1'b1;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          baud_q <= '0;
          if (pop) begin
            sh_q  <= mem_q[rp_q];
            par_q <= ^mem_q[rp_q];
            st_q  <= S_START;
            tx_q  <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_q <= '0;
            bit_q  <= '0;
            st_q   <= S_DATA;
            tx_q   <= sh_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              st_q <= S_PAR;
              tx_q <= par_q;
`else
              st_q <= S_STOP;
              tx_q <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              sh_q  <= sh_q >> 1;
              tx_q  <= sh_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PAR: begin
          if (bit_end) begin
            baud_q <= '0;
            st_q   <= S_STOP;
            tx_q   <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (pop) begin
              sh_q  <= mem_q[rp_q];
              par_q <= ^mem_q[rp_q];
              st_q  <= S_START;
              tx_q  <= 1'b0;
            end else begin
              st_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          st_q <= S_IDLE;
          tx_q <= 1'b1;
        end
      endcase
    end
  end

  assign oUartToPc = tx_q;

endmodule

// File: tb/tb_uart_tx_driver.sv
// tb_uart_tx_driver: scoreboard bench; a line monitor decodes frames
// and checks them against bytes queued when each write is issued.
module tb_uart_tx_driver;

  localparam int DIV = 33;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        fclk = 1'b0;
  logic        cclk = 1'b0;
  logic        rst, ctrl, wr, rd;
  logic [15:0] wd;
  logic        line;
  logic [15:0] status;

  uart_tx_driver #(
    .CLK_FREQ  (1_000_000),
    .UART_BPS  (30_000),
    .FIFO_DEPTH(16)
  ) dut (
    .iFpgaClock (fclk),
    .iCpuClock  (cclk),
    .iCpuReset  (rst),
    .iUartCtrl  (ctrl),
    .iIoWrite   (wr),
    .iIoRead    (rd),
    .iWriteData (wd),
    .oUartToPc  (line),
    .oUartStatus(status)
  );

  always #5 fclk = ~fclk;
  always #40 cclk = ~cclk;

  int cyc = 0;
  always @(posedge fclk) cyc <= cyc + 1;

  int         n_tests = 0;
  int         n_fail = 0;
  int         frames_seen = 0;
  int         last_end = 0;
  int         gaps[$];
  logic       parq[$];
  logic [8:0] sb[$];
  logic [7:0] wbuf [32];
  logic       mon_en;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] b);
    sb.push_back({^b, b});
  endtask

  // Line monitor: decode each frame and compare against the scoreboard
  initial begin
    logic        prev;
    logic [10:0] bits;
    logic        stable;
    logic [8:0]  e;
    prev = 1'b1;
    forever begin
      @(negedge fclk);
      if (prev === 1'b1 && line === 1'b0 && mon_en) begin
        gaps.push_back(cyc - last_end - 1);
        stable = 1'b1;
        bits = '0;
        for (int b = 0; b < NB; b++) begin
          bits[b] = line;
          for (int c = 1; c < DIV; c++) begin
            @(negedge fclk);
            if (line !== bits[b]) stable = 1'b0;
          end
          if (b < NB - 1) @(negedge fclk);
        end
        last_end = cyc;
        frames_seen++;
        chk("bit_len", stable, 1'b1);
        chk("start_bit", bits[0], 1'b0);
        chk("stop_bit", bits[NB-1], 1'b1);
        parq.push_back(bits[9]);
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame: got %0h, expected none",
                   bits[8:1]);
        end else begin
          e = sb.pop_front();
          chk("frame_data", bits[8:1], e[7:0]);
`ifdef UART_TX_PARITY_EN
          chk("parity_bit", bits[9], e[8]);
`endif
        end
      end
      prev = line;
    end
  end

  task automatic wr_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge cclk);
      ctrl = 1'b1;
      wr   = 1'b1;
      wd   = {8'hA5, wbuf[i]};
    end
    @(posedge cclk);
    ctrl = 1'b0;
    wr   = 1'b0;
  endtask

  task automatic cpu_read(output logic [15:0] s);
    @(posedge cclk);
    ctrl = 1'b1;
    rd   = 1'b1;
    @(posedge cclk);
    ctrl = 1'b0;
    rd   = 1'b0;
    #1 s = status;
  endtask

  task automatic wait_frames(input int n);
    int t, lim;
    t = 0;
    lim = (n - frames_seen + 2) * NB * DIV;
    while (frames_seen < n && t < lim) begin
      @(negedge fclk);
      t++;
    end
    chk("frames_done", frames_seen >= n, 1'b1);
    @(negedge fclk);
  endtask

  task automatic count_lows(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge fclk);
      if (line !== 1'b1) lows++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s;
    int base, lows, t;
    rst = 1'b0;
    ctrl = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    wd = '0;
    mon_en = 1'b1;
    #1 rst = 1'b1;
    repeat (5) @(negedge fclk);
    chk("reset_line", line, 1'b1);
    chk("reset_status", status, 16'h0002);
    #2 rst = 1'b0;
    repeat (4) @(posedge cclk);

    // single byte 0x55, busy during frame, idle status afterwards
    base = frames_seen;
    push_exp(8'h55);
    wbuf[0] = 8'h55;
    wr_burst(1);
    repeat (6) @(posedge cclk);
    cpu_read(s);
    chk("busy_mid_frame", s[0], 1'b1);
    wait_frames(base + 1);
    repeat (4) @(posedge cclk);
    cpu_read(s);
    chk("status_idle", s, 16'h0002);

    // write strobe without address select: nothing sent
    base = frames_seen;
    @(posedge cclk);
    wr = 1'b1;
    wd = 16'h003C;
    @(posedge cclk);
    wr = 1'b0;
    count_lows(2 * NB * DIV, lows);
    chk("nosel_line_low", lows, 0);
    chk("nosel_frames", frames_seen, base);

    // back-to-back bytes: contiguous frames in order
    base = frames_seen;
    wbuf[0] = 8'h41;
    wbuf[1] = 8'h42;
    wbuf[2] = 8'h43;
    for (int i = 0; i < 3; i++) push_exp(wbuf[i]);
    wr_burst(3);
    wait_frames(base + 3);
    chk("gap_frame2", gaps[base+1], 0);
    chk("gap_frame3", gaps[base+2], 0);

    // overflow: 18 writes during first frame, 17 go out
    base = frames_seen;
    for (int i = 0; i < 18; i++) begin
      wbuf[i] = 8'h10 + 8'(i);
      if (i < 17) push_exp(wbuf[i]);
    end
    wr_burst(18);
    repeat (4) @(posedge cclk);
    cpu_read(s);
    chk("status_ovf_full", s, 16'h000D);
    wait_frames(base + 17);
    repeat (6) @(posedge cclk);
    cpu_read(s);
    chk("status_ovf_cleared", s, 16'h0002);

`ifdef UART_TX_PARITY_EN
    base = frames_seen;
    wbuf[0] = 8'h07;
    wbuf[1] = 8'h03;
    push_exp(8'h07);
    push_exp(8'h03);
    wr_burst(2);
    wait_frames(base + 2);
    chk("parity_07", parq[base], 1'b1);
    chk("parity_03", parq[base+1], 1'b0);
`endif

    // reset mid-frame aborts immediately
    mon_en = 1'b0;
    base = frames_seen;
    wbuf[0] = 8'h00;
    wr_burst(1);
    t = 0;
    while (line !== 1'b0 && t < 4 * NB * DIV) begin
      @(negedge fclk);
      t++;
    end
    chk("abort_frame_started", line, 1'b0);
    repeat (5 * DIV + DIV / 2) @(negedge fclk);
    chk("pre_reset_line", line, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("abort_line_high", line, 1'b1);
    chk("abort_status", status, 16'h0002);
    repeat (3) @(negedge fclk);
    #2 rst = 1'b0;
    count_lows(2 * NB * DIV, lows);
    chk("abort_no_frames", lows, 0);
    cpu_read(s);
    chk("abort_status_read", s, 16'h0002);
    mon_en = 1'b1;

    chk("frames_total", frames_seen, base);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
